// File: rtl/priority_encoder_scan_display_pkg.sv
// Shared constants for the priority-encoder scan display: hex segment table,
// segment bit order and a constant-friendly clog2.
package priority_encoder_scan_display_pkg;

    localparam int SEG_W = 7;

    // Bit positions inside a {a,b,c,d,e,f,g} segment word.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-high patterns, entry 15 first; b and d are the lowercase glyphs.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-high {a..g} segment decode.
module hex_to_seven_seg
    import priority_encoder_scan_display_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/priority_encoder_scan_display.sv
// Highest-index priority encoder with registered code, scanned onto a
// multi-digit hex seven-segment panel with hold, blanking and polarity options.
module priority_encoder_scan_display
    import priority_encoder_scan_display_pkg::*;
#(
    parameter int N_INPUTS       = 16,
    parameter int DIGITS         = 2,
    parameter int SCAN_DIV       = 1000,
    parameter int LZB            = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    localparam int CODE_W        = clog2(N_INPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] in_i,
    input  logic                hold_mode_i,
    output logic [CODE_W-1:0]   code_o,
    output logic                valid_o,
    output logic [SEG_W-1:0]    seg_o,
    output logic                dp_o,
    output logic [DIGITS-1:0]   an_o
);

    localparam int DIG_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int PSC_W = clog2(SCAN_DIV + 1);
    localparam int NIB_W = 4 * DIGITS;

    logic [N_INPUTS-1:0] sync1_q, sync2_q;
    logic [CODE_W-1:0]   idx, code_q, code_d;
    logic                any, valid_q, valid_d, stale_q, stale_d, seen_q, seen_d;
    logic [PSC_W-1:0]    psc_q, psc_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [DIGITS-1:0][3:0] nib;
    logic [DIGITS-1:0]   upz;
    logic                acc, show, blank_lz;
    logic [3:0]          nib_cur;
    logic [SEG_W-1:0]    seg_hex, seg_d, seg_q;
    logic                dp_d, dp_q;
    logic [DIGITS-1:0]   an_d, an_q;

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sync2_q[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end

    // stale marks a held code that is no longer backed by a live input.
    always_comb begin
        code_d  = code_q;
        valid_d = 1'b0;
        stale_d = 1'b0;
        seen_d  = seen_q;
        if (any) begin
            code_d  = idx;
            valid_d = 1'b1;
            seen_d  = 1'b1;
        end else if (hold_mode_i) begin
            stale_d = seen_q;
        end else begin
            code_d = '0;
        end
    end

    always_comb begin
        psc_d = psc_q + PSC_W'(1);
        dig_d = dig_q;
        if (psc_q == PSC_W'(SCAN_DIV - 1)) begin
            psc_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
    end

    assign nib = NIB_W'(code_q);

    // upz[k]: nibble k and every nibble above it are zero.
    always_comb begin
        upz = '0;
        acc = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            acc    = acc & (nib[k] == 4'h0);
            upz[k] = acc;
        end
    end

    assign show     = valid_q | stale_q;
    assign blank_lz = (LZB != 0) && (dig_q != '0) && upz[dig_q];
    assign nib_cur  = nib[dig_q];

    hex_to_seven_seg u_hex (
        .nibble_i (nib_cur),
        .seg_o    (seg_hex)
    );

    // Display registers follow the current digit index so an, seg and dp
    // switch together and each slot lasts a full SCAN_DIV cycles.
    always_comb begin
        seg_d = (show && !blank_lz) ? seg_hex : '0;
        dp_d  = stale_q && (dig_q == '0);
        an_d  = '0;
        an_d[dig_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            stale_q <= 1'b0;
            seen_q  <= 1'b0;
            psc_q   <= '0;
            dig_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            code_q  <= code_d;
            valid_q <= valid_d;
            stale_q <= stale_d;
            seen_q  <= seen_d;
            psc_q   <= psc_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign code_o  = code_q;
    assign valid_o = valid_q;
    assign seg_o   = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp_o    = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign an_o    = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_priority_encoder_scan_display.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with a
// cycle number; the monitor pops and compares them as that cycle comes up.
module tb_priority_encoder_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_m;
    logic        hold;
    logic [3:0]  code_m;
    logic        valid_m;
    logic [6:0]  seg_m;
    logic        dp_m;
    logic [1:0]  an_m;

    logic [63:0] in_w;
    logic [5:0]  code_w;
    logic        valid_w;
    logic [6:0]  seg_w;
    logic        dp_w;
    logic [1:0]  an_w;

    always #5 clk = ~clk;

    priority_encoder_scan_display #(
        .N_INPUTS(16), .DIGITS(2), .SCAN_DIV(4), .LZB(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_i(in_m), .hold_mode_i(hold),
        .code_o(code_m), .valid_o(valid_m), .seg_o(seg_m), .dp_o(dp_m), .an_o(an_m)
    );

    priority_encoder_scan_display #(
        .N_INPUTS(64), .DIGITS(2), .SCAN_DIV(4), .LZB(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .in_i(in_w), .hold_mode_i(1'b0),
        .code_o(code_w), .valid_o(valid_w), .seg_o(seg_w), .dp_o(dp_w), .an_o(an_w)
    );

    typedef struct {
        int          cyc;
        string       nm;
        bit          w;
        bit          cv;
        logic [7:0]  code;
        logic        vld;
        bit          dsp;
        logic [6:0]  seg;
        logic        dp;
        logic [1:0]  an;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic exp_cv(input int c, input string nm, input bit w,
                          input logic [7:0] code, input logic vld);
        exp_t e;
        e.cyc = c; e.nm = nm; e.w = w; e.cv = 1'b1; e.code = code; e.vld = vld;
        e.dsp = 1'b0; e.seg = '0; e.dp = 1'b0; e.an = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_dsp(input int c, input string nm, input bit w,
                           input logic [6:0] seg, input logic dp, input logic [1:0] an);
        exp_t e;
        e.cyc = c; e.nm = nm; e.w = w; e.cv = 1'b0; e.code = '0; e.vld = 1'b0;
        e.dsp = 1'b1; e.seg = seg; e.dp = dp; e.an = an;
        exp_q.push_back(e);
    endtask

    task automatic exp_all(input int c, input string nm,
                           input logic [7:0] code, input logic vld,
                           input logic [6:0] seg, input logic dp, input logic [1:0] an);
        exp_t e;
        e.cyc = c; e.nm = nm; e.w = 1'b0; e.cv = 1'b1; e.code = code; e.vld = vld;
        e.dsp = 1'b1; e.seg = seg; e.dp = dp; e.an = an;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    exp_t       m_e;
    logic [7:0] a_code;
    logic       a_vld, a_dp, bad;
    logic [6:0] a_seg;
    logic [1:0] a_an;

    always @(negedge clk) begin
        while (exp_q.size() != 0 && (done || exp_q[0].cyc <= cyc)) begin
            m_e = exp_q.pop_front();
            checks++;
            if (done || m_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s not sampled: at cycle %0d, wanted cycle %0d", m_e.nm, cyc, m_e.cyc);
            end else begin
                a_code = m_e.w ? {2'b00, code_w} : {4'h0, code_m};
                a_vld  = m_e.w ? valid_w : valid_m;
                a_seg  = m_e.w ? seg_w   : seg_m;
                a_dp   = m_e.w ? dp_w    : dp_m;
                a_an   = m_e.w ? an_w    : an_m;
                bad = (m_e.cv  && (a_code !== m_e.code || a_vld !== m_e.vld)) ||
                      (m_e.dsp && (a_seg !== m_e.seg || a_dp !== m_e.dp || a_an !== m_e.an));
                if (bad) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got code=%h valid=%b seg=%b dp=%b an=%b want code=%h valid=%b seg=%b dp=%b an=%b",
                             m_e.nm, cyc, a_code, a_vld, a_seg, a_dp, a_an,
                             m_e.code, m_e.vld, m_e.seg, m_e.dp, m_e.an);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_m  = '0;
        in_w  = '0;
        hold  = 1'b0;
        exp_all(0, "reset", 8'h00, 1'b0, 7'h7F, 1'b1, 2'b11);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        in_m  = 16'h0024;
        in_w  = 64'd1 << 37;
        exp_cv (3, "prio_code", 1'b0, 8'h05, 1'b1);
        exp_cv (3, "wide_code", 1'b1, 8'h25, 1'b1);
        exp_dsp(4, "prio_d0_5", 1'b0, 7'b0100100, 1'b1, 2'b10);
        exp_dsp(4, "wide_d0_5", 1'b1, 7'b0100100, 1'b1, 2'b10);
        exp_dsp(6, "prio_d1_lzb", 1'b0, 7'h7F, 1'b1, 2'b01);
        exp_dsp(6, "wide_d1_2", 1'b1, 7'b0010010, 1'b1, 2'b01);

        wait_cyc(8);
        in_m = 16'h8001;
        exp_cv (11, "max_code", 1'b0, 8'h0F, 1'b1);
        exp_dsp(12, "max_d0_F", 1'b0, 7'b0111000, 1'b1, 2'b10);
        exp_dsp(14, "max_d1_lzb", 1'b0, 7'h7F, 1'b1, 2'b01);

        wait_cyc(16);
        in_m = 16'h0400;
        exp_cv(19, "hold_load", 1'b0, 8'h0A, 1'b1);
        wait_cyc(20);
        in_m = 16'h0000;
        hold = 1'b1;
        exp_cv (22, "hold_latency", 1'b0, 8'h0A, 1'b1);
        exp_cv (23, "hold_code", 1'b0, 8'h0A, 1'b0);
        exp_dsp(26, "hold_d0_dp", 1'b0, 7'b0001000, 1'b0, 2'b10);
        exp_dsp(30, "hold_d1_nodp", 1'b0, 7'h7F, 1'b1, 2'b01);

        wait_cyc(32);
        hold = 1'b0;
        exp_cv (33, "nohold_code", 1'b0, 8'h00, 1'b0);
        exp_dsp(34, "nohold_blank", 1'b0, 7'h7F, 1'b1, 2'b10);

        wait_cyc(34);
        in_m = 16'h0400;
        hold = 1'b1;
        wait_cyc(38);
        in_m = 16'h0000;
        exp_cv (41, "rehold_code", 1'b0, 8'h0A, 1'b0);
        exp_dsp(42, "rehold_d0_dp", 1'b0, 7'b0001000, 1'b0, 2'b10);
        exp_dsp(46, "rehold_d1", 1'b0, 7'h7F, 1'b1, 2'b01);

        // Reset in the middle of the digit-1 slot with a held value pending.
        wait_cyc(46);
        rst_n = 1'b0;
        exp_all(0, "midreset", 8'h00, 1'b0, 7'h7F, 1'b1, 2'b11);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_all(1, "post_first_d0", 8'h00, 1'b0, 7'h7F, 1'b1, 2'b10);
        exp_dsp(4, "post_d0_full", 1'b0, 7'h7F, 1'b1, 2'b10);
        exp_dsp(5, "post_d1", 1'b0, 7'h7F, 1'b1, 2'b01);
        exp_all(9, "post_d0_again", 8'h00, 1'b0, 7'h7F, 1'b1, 2'b10);

        wait_cyc(10);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
